time_set_controller: RTL and testbench

Sequences the three-level counter core's load interface so the user can set the time with three debounced buttons. It freezes the core, captures the current value into shadow registers, and lets the user edit level 2, level 1 and level 0 in turn with increment/decrement plus auto-repeat. It then commits all three levels with a one-cycle load strobe. It also drives per-field blink-blanking for the LED display mux and aborts the edit on inactivity.

---
 rtl/time_set_controller.sv | 216 +++++++++++++++++++++
 tb/tb_time_set_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// Time-set sequencer for the three-level counter core: freezes the core, edits shadow copies
// of L2/L1/L0 with inc/dec and auto-repeat, then commits them with a one-cycle active-low load strobe.
module time_set_controller #(
  parameter int L0_LIMIT     = 60,
  parameter int L1_LIMIT     = 60,
  parameter int L2_LIMIT     = 24,
  parameter int BLINK_HALF   = 250000,
  parameter int REPEAT_DELAY = 250000,
  parameter int REPEAT_RATE  = 50000,
  parameter int TIMEOUT      = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [5:0] cur_l0,
  input  logic [5:0] cur_l1,
  input  logic [5:0] cur_l2,
  output logic       enabled,
  output logic       modify_n,
  output logic [5:0] l0_in,
  output logic [5:0] l1_in,
  output logic [5:0] l2_in,
  output logic [1:0] field_sel,
  output logic       blank_l0,
  output logic       blank_l1,
  output logic       blank_l2
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT + 1);

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [REP_W-1:0]   DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0]   RATE_LAST  = REP_W'(REPEAT_RATE - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT - 1);
  localparam logic [6:0]         LIM0       = 7'(L0_LIMIT);
  localparam logic [6:0]         LIM1       = 7'(L1_LIMIT);
  localparam logic [6:0]         LIM2       = 7'(L2_LIMIT);

  typedef enum logic [2:0] {S_RUN, S_SET_L2, S_SET_L1, S_SET_L0, S_COMMIT} state_t;

  state_t             r_state;
  logic               r_mode_d, r_inc_d, r_dec_d;
  logic               r_mode_p, r_inc_p, r_dec_p;
  logic [5:0]         r_sh0, r_sh1, r_sh2;
  logic [5:0]         r_l0_in, r_l1_in, r_l2_in;
  logic               r_enabled, r_modify_n, r_phase, r_rep_armed;
  logic [1:0]         r_field_sel;
  logic [REP_W-1:0]   r_rep_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic [IDLE_W-1:0]  r_idle;

  state_t     w_next_state;
  logic       w_in_set, w_next_in_set, w_field_chg, w_any_press;
  logic       w_one_held, w_press_step, w_rep_step, w_step, w_timeout;
  logic [5:0] w_sel_val, w_step_val;
  logic [6:0] w_sel_lim;
  logic [5:0] w_sh0_next, w_sh1_next, w_sh2_next;
  logic [1:0] w_next_field;

  function automatic logic [5:0] f_clamp(input logic [5:0] v, input logic [6:0] lim);
    return ({1'b0, v} >= lim) ? 6'd0 : v;
  endfunction

  function automatic logic [5:0] f_step(input logic [5:0] v, input logic [6:0] lim, input logic up);
    logic [6:0] last;
    last = lim - 7'd1;
    if (up) return ({1'b0, v} == last) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? last[5:0] : v - 6'd1;
  endfunction

  always_comb begin
    w_in_set     = (r_state == S_SET_L2) || (r_state == S_SET_L1) || (r_state == S_SET_L0);
    w_any_press  = r_mode_p | r_inc_p | r_dec_p;
    // exactly one of inc/dec held; both held cancels stepping
    w_one_held   = r_inc_d ^ r_dec_d;
    w_press_step = w_in_set && w_one_held && (r_inc_p || r_dec_p);
    w_rep_step   = w_in_set && w_one_held && !(r_inc_p || r_dec_p) &&
                   (r_rep_armed ? (r_rep_cnt == RATE_LAST) : (r_rep_cnt == DELAY_LAST));
    w_step       = w_press_step || w_rep_step;
    w_timeout    = w_in_set && (r_idle == IDLE_LAST) && !w_any_press && !w_rep_step;

    w_sel_val = r_sh2;
    w_sel_lim = LIM2;
    case (r_state)
      S_SET_L1: begin w_sel_val = r_sh1; w_sel_lim = LIM1; end
      S_SET_L0: begin w_sel_val = r_sh0; w_sel_lim = LIM0; end
      default:  ;
    endcase
    w_step_val = f_step(w_sel_val, w_sel_lim, r_inc_d);

    w_next_state = r_state;
    case (r_state)
      S_RUN:    if (r_mode_p) w_next_state = S_SET_L2;
      S_SET_L2: if (r_mode_p) w_next_state = S_SET_L1; else if (w_timeout) w_next_state = S_RUN;
      S_SET_L1: if (r_mode_p) w_next_state = S_SET_L0; else if (w_timeout) w_next_state = S_RUN;
      S_SET_L0: if (r_mode_p) w_next_state = S_COMMIT; else if (w_timeout) w_next_state = S_RUN;
      S_COMMIT: w_next_state = S_RUN;
      default:  w_next_state = S_RUN;
    endcase
    w_next_in_set = (w_next_state == S_SET_L2) || (w_next_state == S_SET_L1) ||
                    (w_next_state == S_SET_L0);
    w_field_chg   = (w_next_state != r_state);

    case (w_next_state)
      S_SET_L2: w_next_field = 2'd3;
      S_SET_L1: w_next_field = 2'd2;
      S_SET_L0: w_next_field = 2'd1;
      default:  w_next_field = 2'd0;
    endcase

    w_sh0_next = r_sh0;
    w_sh1_next = r_sh1;
    w_sh2_next = r_sh2;
    if (r_state == S_RUN && r_mode_p) begin
      w_sh0_next = f_clamp(cur_l0, LIM0);
      w_sh1_next = f_clamp(cur_l1, LIM1);
      w_sh2_next = f_clamp(cur_l2, LIM2);
    end else if (w_step) begin
      case (r_state)
        S_SET_L2: w_sh2_next = w_step_val;
        S_SET_L1: w_sh1_next = w_step_val;
        S_SET_L0: w_sh0_next = w_step_val;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_mode_d    <= 1'b0;
      r_inc_d     <= 1'b0;
      r_dec_d     <= 1'b0;
      r_mode_p    <= 1'b0;
      r_inc_p     <= 1'b0;
      r_dec_p     <= 1'b0;
      r_sh0       <= 6'd0;
      r_sh1       <= 6'd0;
      r_sh2       <= 6'd0;
      r_l0_in     <= 6'd0;
      r_l1_in     <= 6'd0;
      r_l2_in     <= 6'd0;
      r_enabled   <= 1'b1;
      r_modify_n  <= 1'b1;
      r_field_sel <= 2'd0;
      r_phase     <= 1'b0;
      r_rep_armed <= 1'b0;
      r_rep_cnt   <= '0;
      r_blink_cnt <= '0;
      r_idle      <= '0;
    end else begin
      r_mode_d    <= btn_mode;
      r_inc_d     <= btn_inc;
      r_dec_d     <= btn_dec;
      r_mode_p    <= btn_mode & ~r_mode_d;
      r_inc_p     <= btn_inc & ~r_inc_d;
      r_dec_p     <= btn_dec & ~r_dec_d;

      r_state     <= w_next_state;
      r_enabled   <= (w_next_state == S_RUN);
      r_modify_n  <= (w_next_state != S_COMMIT);
      r_field_sel <= w_next_field;
      r_sh0       <= w_sh0_next;
      r_sh1       <= w_sh1_next;
      r_sh2       <= w_sh2_next;
      // load values track the shadows through edit and commit, then hold in RUN
      if (r_state != S_RUN || w_next_state != S_RUN) begin
        r_l0_in <= w_sh0_next;
        r_l1_in <= w_sh1_next;
        r_l2_in <= w_sh2_next;
      end

      if (!w_in_set || !w_one_held || r_inc_p || r_dec_p) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b0;
      end else if (w_rep_step) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b1;
      end else begin
        r_rep_cnt   <= r_rep_cnt + 1'b1;
      end

      // restart blink visible whenever the edited value or field changes
      if (!w_next_in_set || w_field_chg || w_step) begin
        r_blink_cnt <= '0;
        r_phase     <= 1'b0;
      end else if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end

      if (!w_next_in_set || w_field_chg || w_any_press || w_rep_step)
        r_idle <= '0;
      else
        r_idle <= r_idle + 1'b1;
    end
  end

  assign enabled   = r_enabled;
  assign modify_n  = r_modify_n;
  assign l0_in     = r_l0_in;
  assign l1_in     = r_l1_in;
  assign l2_in     = r_l2_in;
  assign field_sel = r_field_sel;
  assign blank_l0  = r_phase && (r_field_sel == 2'd1);
  assign blank_l1  = r_phase && (r_field_sel == 2'd2);
  assign blank_l2  = r_phase && (r_field_sel == 2'd3);

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller with shortened timers.
module tb_time_set_controller;
  localparam int L0L = 60, L1L = 60, L2L = 24;
  localparam int BH = 8, RD = 10, RR = 4, TO = 60;

  logic       clock = 1'b0;
  logic       reset, btn_mode, btn_inc, btn_dec;
  logic [5:0] cur_l0, cur_l1, cur_l2;
  logic       enabled, modify_n, blank_l0, blank_l1, blank_l2;
  logic [5:0] l0_in, l1_in, l2_in;
  logic [1:0] field_sel;

  always #5 clock = ~clock;

  time_set_controller #(
    .L0_LIMIT(L0L), .L1_LIMIT(L1L), .L2_LIMIT(L2L), .BLINK_HALF(BH),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_l0(cur_l0), .cur_l1(cur_l1), .cur_l2(cur_l2), .enabled(enabled), .modify_n(modify_n),
    .l0_in(l0_in), .l1_in(l1_in), .l2_in(l2_in), .field_sel(field_sel),
    .blank_l0(blank_l0), .blank_l1(blank_l1), .blank_l2(blank_l2)
  );

  typedef struct packed {
    logic       en;
    logic       mn;
    logic [1:0] fs;
    logic [5:0] l2;
    logic [5:0] l1;
    logic [5:0] l0;
    logic [2:0] bl;
  } obs_t;

  obs_t       sb_q[$];
  obs_t       e, o;
  int         n_cmp = 0, n_bad = 0;
  int         commit_cnt = 0;
  logic [5:0] cm2, cm1, cm0;
  int         m2, m1, m0;

  function automatic obs_t sample();
    return {enabled, modify_n, field_sel, l2_in, l1_in, l0_in, blank_l2, blank_l1, blank_l0};
  endfunction

  function automatic obs_t mk(input bit en, input bit mn, input int fs,
                              input int v2, input int v1, input int v0, input int bl);
    obs_t r;
    r.en = en; r.mn = mn; r.fs = 2'(fs);
    r.l2 = 6'(v2); r.l1 = 6'(v1); r.l0 = 6'(v0); r.bl = 3'(bl);
    return r;
  endfunction

  function automatic int nxt(input int v, input int lim, input bit up);
    if (up) return (v == lim - 1) ? 0 : v + 1;
    return (v == 0) ? lim - 1 : v - 1;
  endfunction

  always @(negedge clock)
    if (reset === 1'b0 && modify_n === 1'b0) begin
      commit_cnt++;
      cm2 = l2_in; cm1 = l1_in; cm0 = l0_in;
    end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // one-cycle press then one idle cycle: the effect is visible on return
  task automatic tap(input int which);
    if (which == 0) btn_mode = 1'b1; else if (which == 1) btn_inc = 1'b1; else btn_dec = 1'b1;
    cyc(1);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset(input int a2, input int a1, input int a0);
    reset = 1'b1;
    cur_l2 = 6'(a2); cur_l1 = 6'(a1); cur_l0 = 6'(a0);
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_mode = 0; btn_inc = 0; btn_dec = 0;
    cur_l2 = 6'd12; cur_l1 = 6'd34; cur_l0 = 6'd56;
    sb_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    cyc(2);
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL reset_state: got %h expected %h", o, e); end
    reset = 1'b0;
    sb_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    cyc(3);
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL idle_run: got %h expected %h", o, e); end
  endtask

  task automatic test_enter_set();
    btn_mode = 1'b1;
    sb_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    cyc(1);
    btn_mode = 1'b0;
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL mode_latency1: got %h expected %h", o, e); end
    m2 = 12; m1 = 34; m0 = 56;
    sb_q.push_back(mk(0, 1, 3, m2, m1, m0, 0));
    cyc(1);
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL enter_set: got %h expected %h", o, e); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 13; i++) begin tap(2); m2 = nxt(m2, L2L, 0); end
    sb_q.push_back(mk(0, 1, 3, 23, m1, m0, 0));
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL dec_to_23: got %h expected %h", o, e); end
    tap(1); m2 = nxt(m2, L2L, 1);
    sb_q.push_back(mk(0, 1, 3, 0, m1, m0, 0));
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL inc_wrap: got %h expected %h", o, e); end
    tap(2); m2 = nxt(m2, L2L, 0);
    sb_q.push_back(mk(0, 1, 3, 23, m1, m0, 0));
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL dec_wrap: got %h expected %h", o, e); end
    sb_q.push_back(mk(0, 1, 3, m2, m1, m0, 3'b100));
    cyc(BH);
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL blink_on: got %h expected %h", o, e); end
    tap(1); m2 = nxt(m2, L2L, 1);
    sb_q.push_back(mk(0, 1, 3, m2, m1, m0, 0));
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL step_unblanks: got %h expected %h", o, e); end
    n_cmp++;
    if (commit_cnt !== 0) begin n_bad++; $display("FAIL no_commit_edit: got %0d expected 0", commit_cnt); end
  endtask

  task automatic test_commit();
    do_reset(4, 7, 7);
    tap(0); tap(1); tap(0);
    sb_q.push_back(mk(0, 1, 2, 5, 7, 7, 0));
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL adv_l1: got %h expected %h", o, e); end
    tap(2); tap(0);
    sb_q.push_back(mk(0, 1, 1, 5, 6, 7, 0));
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL adv_l0: got %h expected %h", o, e); end
    btn_mode = 1'b1;
    cyc(1);
    btn_mode = 1'b0;
    sb_q.push_back(mk(0, 0, 0, 5, 6, 7, 0));
    cyc(1);
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL commit_cycle: got %h expected %h", o, e); end
    sb_q.push_back(mk(1, 1, 0, 5, 6, 7, 0));
    cyc(1);
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL after_commit: got %h expected %h", o, e); end
    cyc(3);
    n_cmp++;
    if (commit_cnt !== 1) begin n_bad++; $display("FAIL commit_once: got %0d expected 1", commit_cnt); end
    n_cmp++;
    if ({cm2, cm1, cm0} !== {6'd5, 6'd6, 6'd7})
      begin n_bad++; $display("FAIL commit_vals: got %0d/%0d/%0d expected 5/6/7", cm2, cm1, cm0); end
    tap(1);
    sb_q.push_back(mk(1, 1, 0, 5, 6, 7, 0));
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL run_inc_ignored: got %h expected %h", o, e); end
  endtask

  task automatic test_repeat();
    do_reset(0, 58, 0);
    tap(0); tap(0);
    m1 = 58;
    btn_inc = 1'b1;
    cyc(2); m1 = nxt(m1, L1L, 1);
    sb_q.push_back(mk(0, 1, 2, 0, m1, 0, 0));
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL rep_first: got %h expected %h", o, e); end
    cyc(RD - 1);
    sb_q.push_back(mk(0, 1, 2, 0, m1, 0, 3'b010));
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL rep_before_delay: got %h expected %h", o, e); end
    cyc(1); m1 = nxt(m1, L1L, 1);
    sb_q.push_back(mk(0, 1, 2, 0, m1, 0, 0));
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL rep_delay_step: got %h expected %h", o, e); end
    for (int i = 0; i < 3; i++) m1 = nxt(m1, L1L, 1);
    sb_q.push_back(mk(0, 1, 2, 0, 3, 0, 0));
    cyc(3 * RR);
    btn_inc = 1'b0;
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL rep_final: got %h expected %h", o, e); end
    sb_q.push_back(mk(0, 1, 2, 0, m1, 0, 0));
    cyc(RR + 1);
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL rep_release: got %h expected %h", o, e); end
    btn_inc = 1'b1; btn_dec = 1'b1;
    cyc(1);
    btn_inc = 1'b0; btn_dec = 1'b0;
    sb_q.push_back(mk(0, 1, 2, 0, m1, 0, 0));
    cyc(1);
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL both_no_step: got %h expected %h", o, e); end
  endtask

  task automatic test_timeout_blink();
    int c0;
    do_reset(30, 2, 3);
    c0 = commit_cnt;
    tap(0);
    sb_q.push_back(mk(0, 1, 3, 0, 2, 3, 0));
    cyc(BH - 1);
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL blink_pre_half: got %h expected %h", o, e); end
    sb_q.push_back(mk(0, 1, 3, 0, 2, 3, 3'b100));
    cyc(1);
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL blink_half: got %h expected %h", o, e); end
    sb_q.push_back(mk(0, 1, 3, 0, 2, 3, 0));
    cyc(BH);
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL blink_full: got %h expected %h", o, e); end
    sb_q.push_back(mk(0, 1, 3, 0, 2, 3, 3'b100));
    cyc(TO - 1 - 2 * BH);
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL pre_timeout: got %h expected %h", o, e); end
    sb_q.push_back(mk(1, 1, 0, 0, 2, 3, 0));
    cyc(1);
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL timeout_run: got %h expected %h", o, e); end
    cyc(2);
    n_cmp++;
    if (commit_cnt !== c0) begin n_bad++; $display("FAIL timeout_no_commit: got %0d expected %0d", commit_cnt, c0); end
  endtask

  task automatic test_reset_mid();
    int c0;
    do_reset(9, 8, 7);
    c0 = commit_cnt;
    tap(0); tap(0); tap(0);
    sb_q.push_back(mk(0, 1, 1, 9, 8, 7, 0));
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL mid_set_l0: got %h expected %h", o, e); end
    #2 reset = 1'b1;
    sb_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    #1;
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL reset_async: got %h expected %h", o, e); end
    cyc(2);
    reset = 1'b0;
    sb_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    cyc(5);
    e = sb_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL reset_no_resume: got %h expected %h", o, e); end
    n_cmp++;
    if (commit_cnt !== c0) begin n_bad++; $display("FAIL reset_no_commit: got %0d expected %0d", commit_cnt, c0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_enter_set();
    test_wrap();
    test_commit();
    test_repeat();
    test_timeout_blink();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
